emmc_blk_bridge: RTL and testbench

- Upstream user-side adapter for the eMMC state machine; converts request/stream handshakes into its `start/we/blk_cnt` pulse interface and byte-per-`dvalid` data strobes.
- The eMMC side has no backpressure, so a shared byte FIFO decouples the two sides:
  - write: one full block is prefetched before the transfer starts;
  - read: bytes are captured on every strobe and drained by the user with valid/ready.

---
 rtl/emmc_blk_bridge_if.sv | 50 +++++
 rtl/emmc_blk_bridge.sv | 166 ++++++++++++++++
 tb/tb_emmc_blk_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/emmc_blk_bridge_if.sv
// User-side and card-side signal bundle for emmc_blk_bridge.
// err_timeout_o exists only when EMMC_BLK_BRIDGE_TIMEOUT_EN is defined.
interface emmc_blk_bridge_if #(
    parameter int BLK_CNT_W = 16
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [BLK_CNT_W-1:0] req_blk_cnt_i;
    logic [7:0]           wr_data_i;
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [7:0]           rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_ready_i;
    logic                 sm_ready_i;
    logic                 sm_start_o;
    logic                 sm_we_o;
    logic [BLK_CNT_W-1:0] sm_blk_cnt_o;
    logic [7:0]           sm_dat_o;
    logic [7:0]           sm_dat_i;
    logic                 sm_dvalid_i;
    logic                 busy_o;
    logic                 err_underrun_o;
    logic                 err_overrun_o;
    logic                 err_clr_i;
`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
    logic                 err_timeout_o;
`endif

    modport slave (
        input  req_valid_i, req_we_i, req_blk_cnt_i, wr_data_i, wr_valid_i, rd_ready_i,
        input  sm_ready_i, sm_dat_i, sm_dvalid_i, err_clr_i,
        output req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, sm_start_o, sm_we_o,
        output sm_blk_cnt_o, sm_dat_o, busy_o, err_underrun_o, err_overrun_o
`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
        , output err_timeout_o
`endif
    );

    modport master (
        output req_valid_i, req_we_i, req_blk_cnt_i, wr_data_i, wr_valid_i, rd_ready_i,
        output sm_ready_i, sm_dat_i, sm_dvalid_i, err_clr_i,
        input  req_ready_o, wr_ready_o, rd_data_o, rd_valid_o, sm_start_o, sm_we_o,
        input  sm_blk_cnt_o, sm_dat_o, busy_o, err_underrun_o, err_overrun_o
`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
        , input err_timeout_o
`endif
    );
endinterface

// File: rtl/emmc_blk_bridge.sv
// Block bridge between user streams and the eMMC state machine, through a shared FWFT byte FIFO.
// Optional watchdog enabled by EMMC_BLK_BRIDGE_TIMEOUT_EN.
module emmc_blk_bridge #(
    parameter int BLK_CNT_W  = 16,
    parameter int FIFO_DEPTH = 1024
`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic             clk_i,
    input  logic             arst_i,
    emmc_blk_bridge_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = BLK_CNT_W + 9;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [TW-1:0] CNT_ONE = TW'(1);

    // state   | meaning
    // IDLE    | waiting for a request; read data may still be draining
    // WR_FILL | prefetching the first write block from the user
    // RD_WAIT | read accepted, waiting for the state machine to be idle
    // START   | start strobe held until the state machine leaves idle
    // RUN     | bytes moving on the card side
    typedef enum logic [2:0] {IDLE, WR_FILL, RD_WAIT, START, RUN} state_t;
    state_t state, state_nxt;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr, count;
    logic                 full, empty, push, pop, flush;
    logic [7:0]           head, push_data;
    logic                 live;
    logic                 we_lat;
    logic [BLK_CNT_W-1:0] blk_lat;
    logic [TW-1:0]        tot, in_cnt, out_cnt;
    logic                 accept, xfer, strobe, timeout;
    logic                 user_push, user_pop, card_push, card_pop;
    logic                 set_under, set_over, err_under, err_over;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    assign accept    = bus.req_valid_i && bus.req_ready_o;
    assign xfer      = (state == START) || (state == RUN);
    assign strobe    = xfer && bus.sm_dvalid_i;
    assign user_push = bus.wr_valid_i && bus.wr_ready_o;
    assign user_pop  = bus.rd_valid_o && bus.rd_ready_i;
    assign card_pop  = strobe && we_lat && !empty;
    assign set_under = strobe && we_lat && empty;
    // a full FIFO can still take a read byte when the user frees a slot in the same cycle
    assign card_push = strobe && !we_lat && (!full || user_pop);
    assign set_over  = strobe && !we_lat && full && !user_pop;
    assign push      = (user_push || card_push) && !flush;
    assign pop       = (user_pop || card_pop) && !flush;
    assign push_data = we_lat ? bus.wr_data_i : bus.sm_dat_i;
    assign flush     = timeout;

    assign bus.rd_valid_o     = !we_lat && !empty;
    assign bus.rd_data_o      = bus.rd_valid_o ? head : 8'd0;
    assign bus.sm_dat_o       = empty ? 8'd0 : head;
    assign bus.sm_we_o        = we_lat;
    assign bus.sm_blk_cnt_o   = blk_lat;
    assign bus.busy_o         = (state != IDLE) || !empty;
    assign bus.err_underrun_o = err_under;
    assign bus.err_overrun_o  = err_over;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.req_ready_o = 1'b0;
        bus.wr_ready_o  = 1'b0;
        bus.sm_start_o  = 1'b0;
        if (we_lat && (state == WR_FILL || xfer))
            bus.wr_ready_o = !full && (in_cnt < tot);
        unique case (state)
            IDLE: begin
                bus.req_ready_o = live && empty;
                if (accept && bus.req_blk_cnt_i != '0)
                    state_nxt = bus.req_we_i ? WR_FILL : RD_WAIT;
            end
            WR_FILL:
                if (count >= (AW+1)'(512) || in_cnt == tot) state_nxt = START;
            RD_WAIT:
                if (bus.sm_ready_i) state_nxt = START;
            START: begin
                bus.sm_start_o = bus.sm_ready_i;
                if (!bus.sm_ready_i) state_nxt = RUN;
            end
            RUN:
                if (bus.sm_ready_i && out_cnt == tot) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            we_lat    <= 1'b0;
            blk_lat   <= '0;
            tot       <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            err_under <= 1'b0;
            err_over  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (accept && bus.req_blk_cnt_i != '0) begin
                we_lat  <= bus.req_we_i;
                blk_lat <= bus.req_blk_cnt_i;
                tot     <= {bus.req_blk_cnt_i, 9'd0};
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (user_push) in_cnt  <= in_cnt + CNT_ONE;
                if (strobe)    out_cnt <= out_cnt + CNT_ONE;
            end
            err_under <= set_under || (err_under && !bus.err_clr_i);
            err_over  <= set_over  || (err_over  && !bus.err_clr_i);
        end
    end

`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_cnt;
    logic           err_to;

    assign timeout           = xfer && (wd_cnt == WDW'(TIMEOUT_CYC));
    assign bus.err_timeout_o = err_to;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wd_cnt <= '0;
            err_to <= 1'b0;
        end else begin
            if (bus.sm_dvalid_i || state_nxt != state) wd_cnt <= '0;
            else if (xfer)                             wd_cnt <= wd_cnt + WDW'(1);
            err_to <= timeout || (err_to && !bus.err_clr_i);
        end
    end
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_emmc_blk_bridge.sv
// Directed scoreboard bench for emmc_blk_bridge: queues of expected card/user bytes, checked by a negedge monitor.
module tb_emmc_blk_bridge;
    localparam int BW = 16;

    logic clk_i  = 1'b0;
    logic arst_i = 1'b1;

    emmc_blk_bridge_if #(.BLK_CNT_W(BW)) bif ();

    emmc_blk_bridge #(
        .BLK_CNT_W (BW),
        .FIFO_DEPTH(1024)
`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
        , .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .bus   (bif.slave)
    );

    always #5 clk_i = ~clk_i;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sm_q[$];
    logic [7:0] rd_q[$];
    bit         chk_sm = 0;
    bit         start_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: compares every byte the DUT hands over against the expected queues
    always @(negedge clk_i) begin
        if (!arst_i) begin
            if (bif.sm_start_o) start_seen = 1;
            if (chk_sm && bif.sm_dvalid_i) begin
                if (sm_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sm_dat: strobe with no expected byte, got 0x%0h", bif.sm_dat_o);
                end else check("sm_dat", {24'd0, bif.sm_dat_o}, {24'd0, sm_q.pop_front()});
            end
            if (bif.rd_valid_o && bif.rd_ready_i) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rd_data: pop with no expected byte, got 0x%0h", bif.rd_data_o);
                end else check("rd_data", {24'd0, bif.rd_data_o}, {24'd0, rd_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, {31'd0, bif.req_ready_o}, 0);
        check({tag, "_wr_ready"},  {31'd0, bif.wr_ready_o}, 0);
        check({tag, "_rd_valid"},  {31'd0, bif.rd_valid_o}, 0);
        check({tag, "_rd_data"},   {24'd0, bif.rd_data_o}, 0);
        check({tag, "_sm_start"},  {31'd0, bif.sm_start_o}, 0);
        check({tag, "_sm_we"},     {31'd0, bif.sm_we_o}, 0);
        check({tag, "_sm_blk"},    {16'd0, bif.sm_blk_cnt_o}, 0);
        check({tag, "_sm_dat"},    {24'd0, bif.sm_dat_o}, 0);
        check({tag, "_busy"},      {31'd0, bif.busy_o}, 0);
        check({tag, "_underrun"},  {31'd0, bif.err_underrun_o}, 0);
        check({tag, "_overrun"},   {31'd0, bif.err_overrun_o}, 0);
`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
        check({tag, "_timeout"},   {31'd0, bif.err_timeout_o}, 0);
`endif
    endtask

    task automatic request(input logic we, input int blk);
        int n = 0;
        bif.req_we_i      = we;
        bif.req_blk_cnt_i = BW'(blk);
        bif.req_valid_i   = 1'b1;
        while (!bif.req_ready_o && n < 50) begin tick(); n++; end
        check("req_accept", {31'd0, bif.req_ready_o}, 1);
        tick();
        bif.req_valid_i = 1'b0;
    endtask

    task automatic push_bytes(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int n = 0;
            bif.wr_data_i  = 8'(first + i);
            bif.wr_valid_i = 1'b1;
            while (!bif.wr_ready_o && n < 50) begin tick(); n++; end
            if (n == 50) check("wr_ready_wait", {31'd0, bif.wr_ready_o}, 1);
            sm_q.push_back(8'(first + i));
            tick();
        end
        bif.wr_valid_i = 1'b0;
    endtask

    // acts as the card state machine: sees start, then drops ready so the bridge enters RUN
    task automatic sm_begin();
        int n = 0;
        while (!bif.sm_start_o && n < 50) begin tick(); n++; end
        check("sm_start", {31'd0, bif.sm_start_o}, 1);
        tick();
        bif.sm_ready_i = 1'b0;
        tick();
    endtask

    task automatic strobes(input int first, input int cnt, input bit expect_rd);
        for (int i = 0; i < cnt; i++) begin
            bif.sm_dvalid_i = 1'b1;
            bif.sm_dat_i    = 8'(first + i);
            if (expect_rd) rd_q.push_back(8'(first + i));
            tick();
        end
        bif.sm_dvalid_i = 1'b0;
    endtask

    initial begin
        int n;
        bif.req_valid_i = 0; bif.req_we_i = 0; bif.req_blk_cnt_i = '0;
        bif.wr_data_i = 0; bif.wr_valid_i = 0; bif.rd_ready_i = 0;
        bif.sm_ready_i = 1; bif.sm_dat_i = 0; bif.sm_dvalid_i = 0; bif.err_clr_i = 0;

        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        arst_i = 0;
        tick(); tick();
        check("idle_req_ready", {31'd0, bif.req_ready_o}, 1);

        // single-block write
        start_seen = 0;
        request(1'b1, 1);
        push_bytes(0, 511);
        check("no_start_before_512", {31'd0, start_seen}, 0);
        push_bytes(511, 1);
        sm_begin();
        check("wr_sm_we", {31'd0, bif.sm_we_o}, 1);
        check("wr_sm_blk", {16'd0, bif.sm_blk_cnt_o}, 1);
        chk_sm = 1;
        strobes(0, 512, 0);
        chk_sm = 0;
        check("wr_all_delivered", sm_q.size(), 0);
        bif.sm_ready_i = 1;
        tick();
        check("wr_idle_busy", {31'd0, bif.busy_o}, 0);
        check("wr_underrun", {31'd0, bif.err_underrun_o}, 0);
        check("wr_overrun", {31'd0, bif.err_overrun_o}, 0);

        // three-block read with 50% user acceptance
        request(1'b0, 3);
        sm_begin();
        for (int i = 0; i < 1536; i++) begin
            bif.sm_dvalid_i = 1;
            bif.sm_dat_i    = 8'(i);
            rd_q.push_back(8'(i));
            bif.rd_ready_i  = i[0];
            tick();
        end
        bif.sm_dvalid_i = 0;
        bif.sm_ready_i  = 1;
        tick();
        check("rd_busy_pending", {31'd0, bif.busy_o}, 1);
        n = 0;
        while (bif.rd_valid_o && n < 5000) begin bif.rd_ready_i = ~bif.rd_ready_i; tick(); n++; end
        bif.rd_ready_i = 0;
        check("rd_all_returned", rd_q.size(), 0);
        check("rd_busy_drained", {31'd0, bif.busy_o}, 0);
        check("rd_no_overrun", {31'd0, bif.err_overrun_o}, 0);

        // overrun with the user stalled
        request(1'b0, 3);
        sm_begin();
        strobes(0, 1024, 1);
        check("ovr_before_1025", {31'd0, bif.err_overrun_o}, 0);
        strobes(1024, 1, 0);
        check("ovr_on_1025", {31'd0, bif.err_overrun_o}, 1);
        strobes(1025, 511, 0);
        bif.sm_ready_i = 1;
        tick();
        bif.err_clr_i = 1;
        tick();
        bif.err_clr_i = 0;
        check("ovr_cleared", {31'd0, bif.err_overrun_o}, 0);
        bif.rd_ready_i = 1;
        n = 0;
        while (bif.rd_valid_o && n < 2000) begin tick(); n++; end
        bif.rd_ready_i = 0;
        check("ovr_fifo_count", n, 1024);
        check("ovr_queue_empty", rd_q.size(), 0);

        // underrun: only one of two blocks supplied
        request(1'b1, 2);
        push_bytes(0, 512);
        sm_begin();
        chk_sm = 1;
        strobes(0, 512, 0);
        chk_sm = 0;
        check("udr_before_513", {31'd0, bif.err_underrun_o}, 0);
        strobes(512, 1, 0);
        check("udr_on_513", {31'd0, bif.err_underrun_o}, 1);
        strobes(513, 511, 0);
        bif.sm_ready_i = 1;
        tick();
        check("udr_idle_busy", {31'd0, bif.busy_o}, 0);
        check("udr_idle_ready", {31'd0, bif.req_ready_o}, 1);
        bif.err_clr_i = 1;
        tick();
        bif.err_clr_i = 0;
        check("udr_cleared", {31'd0, bif.err_underrun_o}, 0);

        // zero-block request is swallowed
        start_seen = 0;
        request(1'b0, 0);
        repeat (3) tick();
        check("zero_no_start", {31'd0, start_seen}, 0);
        check("zero_busy", {31'd0, bif.busy_o}, 0);
        check("zero_keeps_we", {31'd0, bif.sm_we_o}, 1);
        check("zero_keeps_blk", {16'd0, bif.sm_blk_cnt_o}, 2);

        // read request while the state machine is busy, then reset during RUN
        bif.sm_ready_i = 0;
        request(1'b0, 1);
        repeat (5) tick();
        check("rdwait_no_start", {31'd0, start_seen}, 0);
        check("rdwait_busy", {31'd0, bif.busy_o}, 1);
        bif.sm_ready_i = 1;
        sm_begin();
        strobes(0, 3, 0);
        check("run_data_pending", {31'd0, bif.rd_valid_o}, 1);
        #2;
        arst_i = 1;
        #1;
        check_all_zero("mid_reset");
        tick();
        arst_i = 0;
        bif.sm_ready_i = 1;
        tick(); tick();
        check("post_reset_ready", {31'd0, bif.req_ready_o}, 1);

`ifdef EMMC_BLK_BRIDGE_TIMEOUT_EN
        request(1'b0, 1);
        sm_begin();
        repeat (90) tick();
        check("to_not_yet", {31'd0, bif.err_timeout_o}, 0);
        check("to_busy", {31'd0, bif.busy_o}, 1);
        repeat (20) tick();
        check("to_set", {31'd0, bif.err_timeout_o}, 1);
        check("to_idle", {31'd0, bif.busy_o}, 0);
        bif.sm_ready_i = 1;
        bif.err_clr_i = 1;
        tick();
        bif.err_clr_i = 0;
        check("to_cleared", {31'd0, bif.err_timeout_o}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
